// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter.
// Two requesters share one registered write port: port 0 is the pipeline
// write-back stage and port 1 is a long-latency unit such as mul/div.
// Port 0 has fixed priority over port 1.
// Optional feature: define REGFILE_ARB_STARVE_GUARD_EN to build a starvation
// counter. After MAX_WAIT consecutive stalled cycles, port 1 is forced one grant.
// Writes to R0 are accepted but never raise LE; r0_drop pulses instead.
module regfile_write_arbiter #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data,
  output logic          wb_ready,
  input  logic          lu_valid,
  input  logic [AW-1:0] lu_rd,
  input  logic [DW-1:0] lu_data,
  output logic          lu_ready,
  output logic          LE,
  output logic [AW-1:0] RW,
  output logic [DW-1:0] PW,
  output logic          r0_drop
);

  logic          w_override;
  logic          w_wbReady;
  logic          w_luReady;
  logic          w_wbXfer;
  logic          w_luXfer;
  logic          w_anyXfer;
  logic [AW-1:0] w_selRd;
  logic [DW-1:0] w_selData;

  logic          r_le;
  logic [AW-1:0] r_rw;
  logic [DW-1:0] r_pw;
  logic          r_r0Drop;

`ifdef REGFILE_ARB_STARVE_GUARD_EN
  localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

  logic [3:0] r_waitCnt;

  assign w_override = (r_waitCnt == LP_MAX_WAIT);

  // Count consecutive stalled cycles of port 1; saturate at the forcing threshold
  always_ff @(posedge clk) begin
    if (reset) begin
      r_waitCnt <= 4'd0;
    end else if (!lu_valid || w_luXfer) begin
      r_waitCnt <= 4'd0;
    end else if (r_waitCnt != LP_MAX_WAIT) begin
      r_waitCnt <= r_waitCnt + 4'd1;
    end
  end
`else
  assign w_override = 1'b0;
`endif

  // Grant is purely combinational; reset blocks both ports so nothing is accepted
  always_comb begin
    w_wbReady = !reset && !w_override;
    w_luReady = !reset && (w_override || !wb_valid);
  end

  assign wb_ready = w_wbReady;
  assign lu_ready = w_luReady;

  // Select the transferring port; the grant rules make the two transfers exclusive
  always_comb begin
    w_wbXfer  = wb_valid && w_wbReady;
    w_luXfer  = lu_valid && w_luReady;
    w_anyXfer = w_wbXfer || w_luXfer;
    w_selRd   = wb_rd;
    w_selData = wb_data;
    if (w_luXfer) begin
      w_selRd   = lu_rd;
      w_selData = lu_data;
    end
  end

  // Registered write stage; RW/PW hold when idle, R0 writes become a drop pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      r_le     <= 1'b0;
      r_rw     <= '0;
      r_pw     <= '0;
      r_r0Drop <= 1'b0;
    end else if (w_anyXfer) begin
      r_le     <= (w_selRd != '0);
      r_rw     <= w_selRd;
      r_pw     <= w_selData;
      r_r0Drop <= (w_selRd == '0);
    end else begin
      r_le     <= 1'b0;
      r_r0Drop <= 1'b0;
    end
  end

  assign LE      = r_le;
  assign RW      = r_rw;
  assign PW      = r_pw;
  assign r0_drop = r_r0Drop;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter.
// It runs directed scenarios and then constrained-random traffic against a
// transaction-level model. A shadow register file, written by the DUT outputs,
// is compared against the model's expected register contents.
module tb_regfile_write_arbiter;

  localparam int DW       = 32;
  localparam int AW       = 5;
  localparam int MAX_WAIT = 4;
`ifdef REGFILE_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          wb_valid;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          wb_ready;
  logic          lu_valid;
  logic [AW-1:0] lu_rd;
  logic [DW-1:0] lu_data;
  logic          lu_ready;
  logic          LE;
  logic [AW-1:0] RW;
  logic [DW-1:0] PW;
  logic          r0_drop;

  int assertCount;
  int failCount;

  // Reference model state
  int            stallRun;
  logic          expLe;
  logic [AW-1:0] expRw;
  logic [DW-1:0] expPw;
  logic          expDrop;
  logic [DW-1:0] refRf [32];
  logic [DW-1:0] dutRf [32];
  logic          lastWbReady;
  logic          lastLuReady;

  regfile_write_arbiter #(.DW(DW), .AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk      (clk),
    .reset    (reset),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .wb_ready (wb_ready),
    .lu_valid (lu_valid),
    .lu_rd    (lu_rd),
    .lu_data  (lu_data),
    .lu_ready (lu_ready),
    .LE       (LE),
    .RW       (RW),
    .PW       (PW),
    .r0_drop  (r0_drop)
  );

  // Free-running clock, 10 time-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Shadow register file driven only by the DUT write port (no reset, like the real one)
  always @(posedge clk) begin
    if (LE) dutRf[RW] <= PW;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: check grants mid-cycle, advance the model, check the registered port after the edge
  task automatic applyStimulus();
    bit ovr, expWbR, expLuR, wbX, luX;
    @(negedge clk);
    ovr    = GUARD && (stallRun >= MAX_WAIT);
    expWbR = !reset && !ovr;
    expLuR = !reset && (ovr || !wb_valid);
    checkOutput("wb_ready", 64'(wb_ready), 64'(expWbR));
    checkOutput("lu_ready", 64'(lu_ready), 64'(expLuR));
    lastWbReady = wb_ready;
    lastLuReady = lu_ready;
    wbX = wb_valid && expWbR;
    luX = lu_valid && expLuR;
    if (reset) begin
      expLe = 1'b0; expRw = '0; expPw = '0; expDrop = 1'b0;
    end else if (wbX || luX) begin
      expRw   = wbX ? wb_rd : lu_rd;
      expPw   = wbX ? wb_data : lu_data;
      expLe   = (expRw != 0);
      expDrop = (expRw == 0);
      if (expRw != 0) refRf[expRw] = expPw;
    end else begin
      expLe = 1'b0; expDrop = 1'b0;
    end
    if (reset || !lu_valid || luX) stallRun = 0;
    else if (stallRun < MAX_WAIT) stallRun++;
    @(posedge clk);
    #1;
    checkOutput("LE", 64'(LE), 64'(expLe));
    checkOutput("RW", 64'(RW), 64'(expRw));
    checkOutput("PW", 64'(PW), 64'(expPw));
    checkOutput("r0_drop", 64'(r0_drop), 64'(expDrop));
  endtask

  initial begin
    int firstGrant;
    int wbStalls;
    assertCount = 0;
    failCount   = 0;
    stallRun    = 0;
    expLe = 1'b0; expRw = '0; expPw = '0; expDrop = 1'b0;
    lastWbReady = 1'b0; lastLuReady = 1'b0;
    for (int i = 0; i < 32; i++) begin
      refRf[i] = '0;
      dutRf[i] = '0;
    end
    reset = 1'b1;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    lu_valid = 1'b0; lu_rd = '0; lu_data = '0;

    // Reset for two cycles
    applyStimulus();
    applyStimulus();
    reset = 1'b0;

    // Single write
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    applyStimulus();
    checkOutput("single_wbReady", 64'(lastWbReady), 64'd1);
    checkOutput("single_le", 64'(LE), 64'd1);
    checkOutput("single_rw", 64'(RW), 64'd5);
    checkOutput("single_pw", 64'(PW), 64'hDEADBEEF);
    wb_valid = 1'b0;
    applyStimulus();
    checkOutput("single_leLow", 64'(LE), 64'd0);

    // Contention: port 0 first, then port 1 with no bubble
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h11;
    lu_valid = 1'b1; lu_rd = 5'd4; lu_data = 32'h22;
    applyStimulus();
    checkOutput("cont_luWaits", 64'(lastLuReady), 64'd0);
    checkOutput("cont_firstRw", 64'(RW), 64'd3);
    wb_valid = 1'b0;
    applyStimulus();
    checkOutput("cont_luGrant", 64'(lastLuReady), 64'd1);
    checkOutput("cont_secondLe", 64'(LE), 64'd1);
    checkOutput("cont_secondRw", 64'(RW), 64'd4);
    lu_valid = 1'b0;
    applyStimulus();

    // Starvation: port 0 saturates the port
    firstGrant = -1;
    wbStalls   = 0;
    wb_valid = 1'b1; wb_rd = 5'd9;
    lu_valid = 1'b1; lu_rd = 5'd10; lu_data = 32'hA5A5;
    for (int c = 0; c < 20; c++) begin
      wb_data = 32'(c);
      applyStimulus();
      if (!lastWbReady) wbStalls++;
      if (lastLuReady && lu_valid && firstGrant < 0) begin
        firstGrant = c;
        lu_valid = 1'b0;
      end
    end
    checkOutput("starve_grantCycle", 64'(firstGrant), GUARD ? 64'd4 : 64'(-1));
    checkOutput("starve_wbStalls", 64'(wbStalls), GUARD ? 64'd1 : 64'd0);
    wb_valid = 1'b0;
    applyStimulus();
    lu_valid = 1'b0;
    applyStimulus();

    // R0 discard
    lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'hFFFFFFFF;
    applyStimulus();
    checkOutput("r0_luReady", 64'(lastLuReady), 64'd1);
    checkOutput("r0_le", 64'(LE), 64'd0);
    checkOutput("r0_drop", 64'(r0_drop), 64'd1);
    lu_valid = 1'b0;
    applyStimulus();
    checkOutput("r0_dropEnd", 64'(r0_drop), 64'd0);
    checkOutput("r0_rfZero", 64'(dutRf[0]), 64'd0);

    // Reset mid-stream: the in-flight write still lands
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h77;
    applyStimulus();
    wb_valid = 1'b0;
    reset = 1'b1;
    checkOutput("rst_leInFlight", 64'(LE), 64'd1);
    applyStimulus();
    checkOutput("rst_writeLanded", 64'(dutRf[7]), 64'h77);
    checkOutput("rst_leCleared", 64'(LE), 64'd0);
    applyStimulus();
    reset = 1'b0;
    applyStimulus();

    // Back-to-back writes to r1..r8
    for (int i = 1; i <= 8; i++) begin
      wb_valid = 1'b1; wb_rd = AW'(i); wb_data = 32'(i * 32'h101);
      applyStimulus();
      checkOutput("b2b_le", 64'(LE), 64'd1);
      checkOutput("b2b_rw", 64'(RW), 64'(i));
    end
    wb_valid = 1'b0;
    applyStimulus();
    checkOutput("b2b_leEnd", 64'(LE), 64'd0);

    // Random traffic; requesters hold rd/data while stalled
    for (int c = 0; c < 600; c++) begin
      if (!(wb_valid && !lastWbReady)) begin
        wb_valid = ($urandom_range(0, 99) < 60);
        wb_rd    = AW'($urandom);
        wb_data  = $urandom;
      end
      if (!(lu_valid && !lastLuReady)) begin
        lu_valid = ($urandom_range(0, 99) < 50);
        lu_rd    = AW'($urandom);
        lu_data  = $urandom;
      end
      reset = ($urandom_range(0, 39) == 0);
      applyStimulus();
    end

    // Drain and compare the register file image
    reset = 1'b0; wb_valid = 1'b0; lu_valid = 1'b0;
    applyStimulus();
    applyStimulus();
    for (int i = 0; i < 32; i++) begin
      checkOutput($sformatf("rf[%0d]", i), 64'(dutRf[i]), 64'(refRf[i]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
